// File: rtl/not_not_pkg.sv
// Shared types and the answer-mask rule for the Not Not round engine.
package not_not_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_PRESENT,
        ST_WAIT_INPUT,
        ST_JUDGE,
        ST_OVER
    } state_t;

    localparam logic [1:0] OP_SINGLE = 2'd0;
    localparam logic [1:0] OP_AND    = 2'd1;
    localparam logic [1:0] OP_OR     = 2'd2;
    localparam logic [1:0] OP_XOR    = 2'd3;

    localparam int MAX_COLOURS = 8;

    // An odd number of "not" prefixes inverts the answer set within the live colours.
    function automatic logic [MAX_COLOURS-1:0] calc_expected_mask(
        input logic [2:0] a,
        input logic [2:0] b,
        input logic [1:0] op,
        input logic [7:0] depth,
        input int         num_colours
    );
        logic [MAX_COLOURS-1:0] oh_a;
        logic [MAX_COLOURS-1:0] oh_b;
        logic [MAX_COLOURS-1:0] base;
        logic [MAX_COLOURS-1:0] in_range;
        oh_a = MAX_COLOURS'(1) << a;
        oh_b = MAX_COLOURS'(1) << b;
        case (op)
            OP_AND:  base = oh_a & oh_b;
            OP_OR:   base = oh_a | oh_b;
            OP_XOR:  base = oh_a ^ oh_b;
            default: base = oh_a;
        endcase
        in_range = '0;
        for (int i = 0; i < MAX_COLOURS; i++) begin
            if (i < num_colours) in_range[i] = 1'b1;
        end
        if (depth[0]) base = ~base;
        return base & in_range;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR; taps are XORed in whenever the bit shifted out is 1.
module lfsr_galois #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] lfsr_out
);

    logic [WIDTH-1:0] r_lfsr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else if (enable) begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
        end
    end

    assign lfsr_out = r_lfsr;

endmodule

// File: rtl/not_not_round_engine.sv
// Not Not round generator and judge: draws a round, hands it to the display,
// times the player's answer, and keeps score and lives until game over.
module not_not_round_engine
    import not_not_pkg::*;
#(
    parameter int                NUM_COLOURS    = 4,
    parameter int                NOT_W          = 2,
    parameter int                LFSR_W         = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS      = 8'hB8,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 8'h01,
    parameter int                TIMEOUT_CYCLES = 100000000,
    parameter int                SCORE_W        = 8,
    parameter int                MAX_LIVES      = 3,
    localparam int               CW             = $clog2(NUM_COLOURS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   present_done,
    input  logic                   player_valid,
    input  logic [NUM_COLOURS-1:0] player_choice,
    output logic                   round_valid,
    output logic [CW-1:0]          colour_a,
    output logic [CW-1:0]          colour_b,
    output logic [1:0]             logic_op,
    output logic [NOT_W-1:0]       not_depth,
    output logic [NUM_COLOURS-1:0] expected_mask,
    output logic                   answer_open,
    output logic                   result_valid,
    output logic                   result_correct,
    output logic [SCORE_W-1:0]     score,
    output logic [2:0]             lives,
    output logic                   game_over
);

    localparam int             TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     LIVES_INIT = 3'(MAX_LIVES);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [LFSR_W-1:0]        w_lfsr;
    logic [CW-1:0]            w_gen_a;
    logic [CW-1:0]            w_gen_b;
    logic [1:0]               w_gen_op;
    logic [NOT_W-1:0]         w_gen_depth;
    logic [NUM_COLOURS-1:0]   w_gen_mask;
    logic                     w_choice_onehot;
    logic                     w_correct;

    logic [CW-1:0]            r_colour_a;
    logic [CW-1:0]            r_colour_b;
    logic [1:0]               r_logic_op;
    logic [NOT_W-1:0]         r_not_depth;
    logic [NUM_COLOURS-1:0]   r_expected_mask;
    logic [TW-1:0]            r_timer;
    logic [NUM_COLOURS-1:0]   r_choice;
    logic                     r_answered;
    logic [SCORE_W-1:0]       r_score;
    logic [2:0]               r_lives;

    // Free-running so the drawn round depends on when the player acts.
    lfsr_galois #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_TAPS),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .enable   (1'b1),
        .lfsr_out (w_lfsr)
    );

    assign w_gen_a     = w_lfsr[CW-1:0];
    assign w_gen_b     = w_lfsr[2*CW-1:CW];
    assign w_gen_op    = w_lfsr[2*CW+1:2*CW];
    assign w_gen_depth = w_lfsr[2*CW+2+NOT_W-1:2*CW+2];
    assign w_gen_mask  = NUM_COLOURS'(calc_expected_mask(3'(w_gen_a), 3'(w_gen_b), w_gen_op,
                                                         8'(w_gen_depth), NUM_COLOURS));

    assign w_choice_onehot = (r_choice != '0) && ((r_choice & (r_choice - 1'b1)) == '0);
    assign w_correct = r_answered ? (w_choice_onehot && ((r_choice & r_expected_mask) != '0))
                                  : (r_expected_mask == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaults first so no path leaves an output unassigned (no latches).
    always_comb begin
        w_next_state   = r_state;
        round_valid    = 1'b0;
        answer_open    = 1'b0;
        result_valid   = 1'b0;
        result_correct = 1'b0;
        game_over      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_GEN;
            end
            ST_GEN: begin
                w_next_state = ST_PRESENT;
            end
            ST_PRESENT: begin
                round_valid = 1'b1;
                if (present_done) w_next_state = ST_WAIT_INPUT;
            end
            ST_WAIT_INPUT: begin
                round_valid = 1'b1;
                answer_open = 1'b1;
                if (player_valid || (r_timer == '0)) w_next_state = ST_JUDGE;
            end
            ST_JUDGE: begin
                round_valid    = 1'b1;
                result_valid   = 1'b1;
                result_correct = w_correct;
                w_next_state   = (!w_correct && (r_lives == 3'd1)) ? ST_OVER : ST_GEN;
            end
            ST_OVER: begin
                game_over = 1'b1;
                if (start) w_next_state = ST_GEN;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_colour_a      <= '0;
            r_colour_b      <= '0;
            r_logic_op      <= '0;
            r_not_depth     <= '0;
            r_expected_mask <= '0;
            r_timer         <= '0;
            r_choice        <= '0;
            r_answered      <= 1'b0;
            r_score         <= '0;
            r_lives         <= LIVES_INIT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_score <= '0;
                    r_lives <= LIVES_INIT;
                end
                ST_GEN: begin
                    r_colour_a      <= w_gen_a;
                    r_colour_b      <= w_gen_b;
                    r_logic_op      <= w_gen_op;
                    r_not_depth     <= w_gen_depth;
                    r_expected_mask <= w_gen_mask;
                end
                ST_PRESENT: begin
                    if (present_done) r_timer <= TIMER_LOAD;
                end
                ST_WAIT_INPUT: begin
                    // An answer on the expiry cycle still counts as answered.
                    if (player_valid) begin
                        r_choice   <= player_choice;
                        r_answered <= 1'b1;
                    end else if (r_timer == '0) begin
                        r_answered <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_JUDGE: begin
                    if (w_correct) begin
                        if (r_score != '1) r_score <= r_score + 1'b1;
                    end else begin
                        r_lives <= r_lives - 3'd1;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        r_score <= '0;
                        r_lives <= LIVES_INIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign colour_a      = r_colour_a;
    assign colour_b      = r_colour_b;
    assign logic_op      = r_logic_op;
    assign not_depth     = r_not_depth;
    assign expected_mask = r_expected_mask;
    assign score         = r_score;
    assign lives         = r_lives;

endmodule
